// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the detector benches.
// The optional inter-repetition gap is enabled by the SEQ_GAP_EN macro.
package seq_pkg;

  localparam int unsigned SEQ_PAT_W_DEF = 4;
  localparam int unsigned SEQ_CNT_W_DEF = 8;
  localparam int unsigned SEQ_GAP_W_DEF = 4;

  // Target sequence of the overlapping Mealy detector
  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  // Registered serial-side outputs
  typedef struct packed {
    logic dout;
    logic dout_vld;
    logic busy;
    logic done;
  } seq_out_t;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/stream bundle between a pattern source controller and seq_pattern_gen.
// gap is only consumed when SEQ_GAP_EN is defined.
interface seq_pattern_gen_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) ();

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             abort;

  logic             dout;
  logic             dout_vld;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps, gap, abort,
    input  dout, dout_vld, busy, done
  );

  modport slave (
    input  start, pattern, reps, gap, abort,
    output dout, dout_vld, busy, done
  );

endinterface

// File: rtl/seq_pattern_gen_piso_shift.sv
// Parallel-in serial-out shift register: load wins over shift, MSB presented first.
module piso_shift #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = din;
    end else if (shift_en) begin
      sr_d = {sr_q[W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, reps times, then pulses done.
// Define SEQ_GAP_EN to insert gap zero-valued valid bits between repetitions.
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned GAP_W = 4
) (
  input logic               clk,
  input logic               rst,
  seq_pattern_gen_if.slave  bus
);

  localparam int unsigned BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  seq_state_e       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  seq_out_t         out_q, out_d;

  logic             load_c;
  logic             shift_c;
  logic [PAT_W-1:0] load_val_c;
  logic             sr_msb;

`ifdef SEQ_GAP_EN
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
`else
  logic             gap_unused;
  assign gap_unused = ^bus.gap;
`endif

  // Shift register holds the bits still to be sent after the one on dout
  piso_shift #(.W(PAT_W)) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .shift_en (shift_c),
    .din      ({load_val_c[PAT_W-2:0], 1'b0}),
    .msb      (sr_msb)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    pat_d      = pat_q;
    out_d      = '0;
    load_c     = 1'b0;
    shift_c    = 1'b0;
    load_val_c = pat_q;
`ifdef SEQ_GAP_EN
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d    = SHIFT;
          pat_d      = bus.pattern;
          load_val_c = bus.pattern;
          load_c     = 1'b1;
          bit_cnt_d  = BIT_LAST;
          rep_cnt_d  = (bus.reps == '0) ? '0 : bus.reps - CNT_W'(1);
`ifdef SEQ_GAP_EN
          gap_d      = bus.gap;
`endif
          out_d      = '{dout: load_val_c[PAT_W-1], dout_vld: 1'b1, busy: 1'b1, done: 1'b0};
        end
      end

      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bit_cnt_q != '0) begin
          bit_cnt_d = bit_cnt_q - BIT_W'(1);
          shift_c   = 1'b1;
          out_d     = '{dout: sr_msb, dout_vld: 1'b1, busy: 1'b1, done: 1'b0};
        end else if (rep_cnt_q != '0) begin
          rep_cnt_d = rep_cnt_q - CNT_W'(1);
`ifdef SEQ_GAP_EN
          if (gap_q != '0) begin
            state_d   = GAP;
            gap_cnt_d = gap_q - GAP_W'(1);
            out_d     = '{dout: 1'b0, dout_vld: 1'b1, busy: 1'b1, done: 1'b0};
          end else begin
            load_c    = 1'b1;
            bit_cnt_d = BIT_LAST;
            out_d     = '{dout: load_val_c[PAT_W-1], dout_vld: 1'b1, busy: 1'b1, done: 1'b0};
          end
`else
          load_c    = 1'b1;
          bit_cnt_d = BIT_LAST;
          out_d     = '{dout: load_val_c[PAT_W-1], dout_vld: 1'b1, busy: 1'b1, done: 1'b0};
`endif
        end else begin
          state_d = DONE;
          out_d   = '{dout: 1'b0, dout_vld: 1'b0, busy: 1'b0, done: 1'b1};
        end
      end

`ifdef SEQ_GAP_EN
      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (gap_cnt_q == '0) begin
          state_d   = SHIFT;
          load_c    = 1'b1;
          bit_cnt_d = BIT_LAST;
          out_d     = '{dout: load_val_c[PAT_W-1], dout_vld: 1'b1, busy: 1'b1, done: 1'b0};
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          out_d     = '{dout: 1'b0, dout_vld: 1'b1, busy: 1'b1, done: 1'b0};
        end
      end
`endif

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      pat_q     <= '0;
      out_q     <= '0;
`ifdef SEQ_GAP_EN
      gap_q     <= '0;
      gap_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      pat_q     <= pat_d;
      out_q     <= out_d;
`ifdef SEQ_GAP_EN
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
`endif
    end
  end

  assign bus.dout     = out_q.dout;
  assign bus.dout_vld = out_q.dout_vld;
  assign bus.busy     = out_q.busy;
  assign bus.done     = out_q.done;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Bench for seq_pattern_gen: queue-based transfer model checked every cycle, plus directed literals.
// Honors SEQ_GAP_EN for the gap expectations.
module tb_seq_pattern_gen;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 4;

  logic clk;
  logic rst;

  seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) bif ();

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int t0       = 0;
  int rel      = 0;

  // Model: each entry is the expected {dout_vld, dout, busy, done} of one future cycle
  logic [3:0] cur = 4'b0000;
  logic [3:0] q[$];

  logic [63:0] obs_bits, mdl_bits;
  int          obs_len, mdl_len, obs_done_cnt, obs_done_rel, mdl_done_rel;
  logic [3:0]  snap [0:63];

  task automatic build(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g);
    int n;
    n = (r == '0) ? 1 : int'(r);
    for (int k = 0; k < n; k++) begin
      for (int b = PAT_W - 1; b >= 0; b--) q.push_back({1'b1, p[b], 1'b1, 1'b0});
`ifdef SEQ_GAP_EN
      if (k != n - 1) for (int j = 0; j < int'(g); j++) q.push_back(4'b1010);
`else
      if (g == '1 && k < 0) q.push_back(4'b1010);
`endif
    end
    q.push_back(4'b0001);
  endtask

  task automatic model_edge();
    logic [3:0] nxt;
    nxt = 4'b0000;
    if (rst) begin
      q.delete();
    end else if (cur[1] && bif.abort) begin
      q.delete();
    end else if (q.size() != 0) begin
      nxt = q.pop_front();
    end else if (!cur[0] && bif.start && !bif.abort) begin
      build(bif.pattern, bif.reps, bif.gap);
      nxt = q.pop_front();
    end
    cur = nxt;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // One clock: advance the model, then compare every DUT output to it
  task automatic step();
    logic [3:0] act;
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    act = {bif.dout_vld, bif.dout, bif.busy, bif.done};
    checks++;
    if (act !== cur) begin
      failures++;
      $display("FAIL cycle_cmp cyc=%0d got vld/dout/busy/done=%b exp=%b", cyc, act, cur);
    end
    rel = cyc - t0;
    if (rel >= 0 && rel < 64) snap[rel] = act;
    if (bif.dout_vld === 1'b1) begin obs_bits = {obs_bits[62:0], bif.dout}; obs_len++; end
    if (cur[3]) begin mdl_bits = {mdl_bits[62:0], cur[2]}; mdl_len++; end
    if (bif.done === 1'b1) begin obs_done_cnt++; obs_done_rel = rel; end
    if (cur[0]) mdl_done_rel = rel;
  endtask

  task automatic go(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r, input logic [GAP_W-1:0] g,
                    input int ncyc, input int abort_rel, input int rst_rel, input int st1, input int st2);
    obs_bits = '0; mdl_bits = '0; obs_len = 0; mdl_len = 0;
    obs_done_cnt = 0; obs_done_rel = -1; mdl_done_rel = -1;
    for (int i = 0; i < 64; i++) snap[i] = 4'b0000;
    bif.pattern = p; bif.reps = r; bif.gap = g;
    bif.start = 1'b1; bif.abort = 1'b0; rst = 1'b0;
    t0 = cyc;
    for (int i = 0; i < ncyc; i++) begin
      step();
      bif.start = (rel == st1) || (rel == st2);
      bif.abort = (rel == abort_rel);
      rst       = (rel == rst_rel);
      bif.pattern = 4'($urandom);
      bif.reps    = 8'($urandom);
      bif.gap     = 4'($urandom);
    end
    bif.start = 1'b0; bif.abort = 1'b0; rst = 1'b0;
  endtask

  function automatic int count_1011(input logic [63:0] bits, input int len);
    int n;
    logic [3:0] w;
    n = 0;
    for (int i = 0; i + 4 <= len; i++) begin
      w = bits[i +: 4];
      if (w == 4'b1011) n++;
    end
    return n;
  endfunction

  initial begin
    rst = 1'b1;
    bif.start = 1'b0; bif.abort = 1'b0;
    bif.pattern = '0; bif.reps = '0; bif.gap = '0;
    step();
    step();
    chk("reset_outputs", 64'({bif.dout_vld, bif.dout, bif.busy, bif.done}), 64'd0);
    rst = 1'b0;
    step();

    // Single repetition of the detector target
    go(4'b1011, 8'd1, 4'd0, 8, -1, -1, -1, -1);
    chk("r1_len", 64'(obs_len), 64'd4);
    chk("r1_bits", obs_bits, 64'hB);
    chk("r1_model_bits", mdl_bits, 64'hB);
    chk("r1_done_cyc", 64'(obs_done_rel), 64'd5);
    chk("r1_model_done", 64'(mdl_done_rel), 64'd5);
    chk("r1_busy_c4", 64'(snap[4][1]), 64'd1);
    chk("r1_busy_c5", 64'(snap[5][1]), 64'd0);

    // Three contiguous repetitions seen by an overlapping 1011 detector
    go(4'b1011, 8'd3, 4'd0, 16, -1, -1, -1, -1);
    chk("r3_len", 64'(obs_len), 64'd12);
    chk("r3_bits", obs_bits, 64'hBBB);
    chk("r3_model_bits", mdl_bits, 64'hBBB);
    chk("r3_detect", 64'(count_1011(obs_bits, obs_len)), 64'd3);
    chk("r3_done_cyc", 64'(obs_done_rel), 64'd13);

    // reps=0 behaves as reps=1
    go(4'b1011, 8'd0, 4'd0, 8, -1, -1, -1, -1);
    chk("r0_len", 64'(obs_len), 64'd4);
    chk("r0_done_cnt", 64'(obs_done_cnt), 64'd1);
    chk("r0_done_cyc", 64'(obs_done_rel), 64'd5);

    // Abort in cycle 2 of a two-repetition transfer
    go(4'b1011, 8'd2, 4'd0, 10, 2, -1, -1, -1);
    chk("ab_vld_c2", 64'(snap[2][3]), 64'd1);
    chk("ab_vld_c3", 64'(snap[3][3]), 64'd0);
    chk("ab_done_cnt", 64'(obs_done_cnt), 64'd0);
    go(4'b0110, 8'd1, 4'd0, 8, -1, -1, -1, -1);
    chk("ab_next_bits", obs_bits, 64'h6);
    chk("ab_next_done", 64'(obs_done_rel), 64'd5);

    // Starts while busy and in DONE are dropped
    go(4'b1011, 8'd1, 4'd0, 9, -1, -1, 2, 5);
    chk("st_done_cnt", 64'(obs_done_cnt), 64'd1);
    chk("st_len", 64'(obs_len), 64'd4);
    // Reset in cycle 3 of a transfer
    go(4'b1011, 8'd2, 4'd0, 12, -1, 3, -1, -1);
    chk("rs_outputs_c4", 64'(snap[4]), 64'd0);
    chk("rs_len", 64'(obs_len), 64'd3);
    chk("rs_done_cnt", 64'(obs_done_cnt), 64'd0);

`ifdef SEQ_GAP_EN
    go(4'b1011, 8'd2, 4'd2, 14, -1, -1, -1, -1);
    chk("gap_len", 64'(obs_len), 64'd10);
    chk("gap_bits", obs_bits, 64'b1011001011);
    chk("gap_done_cyc", 64'(obs_done_rel), 64'd11);
`else
    go(4'b1011, 8'd2, 4'd3, 12, -1, -1, -1, -1);
    chk("nogap_len", 64'(obs_len), 64'd8);
    chk("nogap_bits", obs_bits, 64'hBB);
    chk("nogap_done_cyc", 64'(obs_done_rel), 64'd9);
`endif

    // Maximum repetition count
    go(4'b1001, 8'hFF, 4'd0, 1024, -1, -1, -1, -1);
    chk("max_len", 64'(obs_len), 64'd1020);
    chk("max_done_cyc", 64'(obs_done_rel), 64'd1021);
    chk("max_done_cnt", 64'(obs_done_cnt), 64'd1);

    // Randomized traffic, including mid-transfer input changes, aborts and resets
    for (int i = 0; i < 4000; i++) begin
      bif.start   = ($urandom_range(0, 3) == 0);
      bif.abort   = ($urandom_range(0, 39) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      bif.pattern = 4'($urandom);
      bif.reps    = 8'($urandom_range(0, 5));
      bif.gap     = 4'($urandom_range(0, 3));
      step();
    end
    rst = 1'b0; bif.start = 1'b0; bif.abort = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial pattern transmitter that drives the sequence-detector family with a bit stream.
- Captures a PAT_W-bit pattern on a start request.
- Shifts the pattern out MSB-first, one bit per clock, repeated a programmable number of times.
- Signals completion with a one-cycle pulse.
- Sits upstream of the overlapping Mealy detector as stimulus source and loopback partner. The default pattern 1011 is that detector's target.

Parameters:
- PAT_W, 4, pattern width in bits (>=2).
- CNT_W, 8, width of repetition count.
- GAP_W, 4, width of inter-repetition gap count (used only with SEQ_GAP_EN).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  transfer request; accepted only in IDLE.
- pattern  in  PAT_W  bits to send; captured on accepted start; MSB sent first.
- reps  in  CNT_W  repetitions; captured on accepted start; 0 treated as 1.
- gap  in  GAP_W  zero-bit cycles between repetitions; captured on start; ignored without SEQ_GAP_EN.
- abort  in  1  terminates an active transfer.
- dout  out  1  serial data; 0 whenever dout_vld=0.
- dout_vld  out  1  dout carries a pattern or gap bit.
- busy  out  1  high in SHIFT and GAP.
- done  out  1  one-cycle pulse after the final bit of the final repetition.

Behaviour:
- Reset: rst sampled high at a rising edge forces state=IDLE and clears dout, dout_vld, busy, done and all internal counters. Reset mid-transfer discards the transfer with no done pulse.
- All outputs are registered; no combinational path from inputs to outputs.
- States and transitions:
  - IDLE: start=1 and abort=0 at edge N → load shift register, bit counter=PAT_W-1, rep counter=max(reps,1)-1; go to SHIFT.
  - SHIFT: dout=shift MSB, dout_vld=1, busy=1; shift left each cycle.
    - Bit counter=0 and rep counter>0 → reload pattern, decrement rep counter; go to GAP if enabled and gap≠0, else stay in SHIFT.
    - Bit counter=0 and rep counter=0 → go to DONE.
  - GAP (SEQ_GAP_EN only): dout=0, dout_vld=1, busy=1 for exactly gap cycles, then SHIFT.
  - DONE: done=1, busy=0, dout_vld=0 for one cycle, then IDLE. start is ignored in DONE.
- Latency: first bit is visible in the cycle after edge N.
  - Busy duration without gaps: reps_eff*PAT_W cycles.
  - done asserts in the cycle after the last bit.
- Back-to-back transfers: earliest next accept is the first IDLE cycle after DONE, giving a two-cycle bubble between streams.
- start while busy or in DONE: ignored and not queued. pattern, reps and gap changes mid-transfer have no effect.
- abort in SHIFT/GAP: next state IDLE, dout_vld=0, no done. abort in IDLE has priority over start, so start is dropped. abort in DONE is ignored and done still pulses.
- Counters never wrap: rep counter saturates at 0 and is checked before decrement. reps=all-ones sends 2^CNT_W-1 repetitions.

Optional Feature:
- Macro SEQ_GAP_EN.
  - Defined: GAP state exists. gap zero-valued, valid bits are inserted between repetitions (not after the last one). gap=0 gives contiguous repetitions.
  - Undefined: GAP state and gap counter are not compiled. The gap port remains but is unused, and repetitions are always contiguous.

Decomposition:
- Package seq_pkg:
  - State encoding localparams: IDLE, SHIFT, GAP, DONE.
  - DEFAULT_PATTERN = 4'b1011.
  - Shared with the detector testbenches.
- One natural sub-module, piso_shift: parameterised parallel-in serial-out register with load, shift enable and MSB output. The FSM and counters remain in seq_pattern_gen.

Test Plan:
- pattern=1011, reps=1, start at cycle 0 → dout 1,0,1,1 with dout_vld=1 in cycles 1-4; done=1 in cycle 5; busy low from cycle 5.
- pattern=1011, reps=3, looped into the overlapping detector → stream 101110111011 contiguous; detector output pulses exactly 3 times; done in cycle 13.
- reps=0 → identical to reps=1 (4 bits, single done).
- abort asserted in cycle 2 of a reps=2 transfer → dout_vld=0 from cycle 3; no done; next start in IDLE is accepted normally.
- start pulsed in cycles 2 and 5 during a busy transfer; rst asserted in cycle 3 of a second transfer → both starts ignored with one done only; after reset all outputs are 0 the next cycle and no done follows.
- SEQ_GAP_EN, pattern=1011, reps=2, gap=2 → dout 1,0,1,1,0,0,1,0,1,1 with dout_vld=1 throughout; done in cycle 11.
